// File: rtl/mnemonic_playback.sv
// Replays a stored list of level-hold durations as a toggling waveform on play_out.
// Entry 0 is played low, levels alternate, and a stored duration of 0 is held for one cycle.
module mnemonic_playback #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [IDX_W:0]   seq_len,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic             play_out,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] cur_idx,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             play_q, play_d;
  logic [CNT_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0] idx_next;
  logic             last_entry;

  function automatic logic [CNT_W-1:0] floor1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign idx_next   = idx_q + IDX_W'(1);
  assign last_entry = ({1'b0, idx_q} == (len_q - (IDX_W+1)'(1)));

  // wr_en is a fire-and-forget strobe with no ready: it lands only while busy is low.
  // The store has no reset so a recording survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q != S_PLAY)) mem_q[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      play_q  <= play_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    play_d  = play_q;
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      play_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop && (seq_len != '0)) begin
            state_d = S_PLAY;
            len_d   = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
            idx_d   = '0;
            cnt_d   = floor1(mem_q[0]);
            play_d  = 1'b0;
          end
        end
        S_PLAY: begin
          if (cnt_q != CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (!last_entry) begin
            idx_d  = idx_next;
            cnt_d  = floor1(mem_q[idx_next]);
            play_d = ~play_q;
          end else if (loop_en) begin
            // Wrap always restarts low, even after an odd number of entries.
            idx_d  = '0;
            cnt_d  = floor1(mem_q[0]);
            play_d = 1'b0;
          end else begin
            state_d = S_DONE;
            play_d  = 1'b0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          play_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    play_out  = play_q;
    busy      = (state_q == S_PLAY);
    done      = (state_q == S_DONE);
    cur_idx   = idx_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_mnemonic_playback.sv
// Directed and randomized playback checks against a waveform model built
// by expanding each stored duration into per-cycle expected levels.
module tb_mnemonic_playback;

  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] wr_idx = '0;
  logic [CNT_W-1:0] wr_data = '0;
  logic [IDX_W:0]   seq_len = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic             play_out;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  int unsigned      model_mem [DEPTH];
  logic [0:0]       exp_q [$];
  logic [IDX_W-1:0] exp_idx_q [$];

  mnemonic_playback #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .seq_len(seq_len), .start(start), .stop(stop), .loop_en(loop_en),
    .play_out(play_out), .busy(busy), .done(done), .cur_idx(cur_idx),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic write_mem(input int idx, input int unsigned data);
    wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_data = data;
    tick();
    wr_en = 1'b0;
    model_mem[idx] = data;
  endtask

  task automatic start_play(input int len);
    seq_len = (IDX_W+1)'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference model: each entry k contributes max(d_k,1) cycles at level k%2.
  task automatic build_model(input int len);
    int n;
    int unsigned d;
    exp_q.delete();
    exp_idx_q.delete();
    n = (len > DEPTH) ? DEPTH : len;
    for (int k = 0; k < n; k++) begin
      d = (model_mem[k] == 0) ? 1 : model_mem[k];
      for (int c = 0; c < int'(d); c++) begin
        exp_q.push_back(1'(k % 2));
        exp_idx_q.push_back(IDX_W'(k));
      end
    end
  endtask

  // Scoreboard over cycles [from, to) of the current pass.
  task automatic check_pass(input string tag, input int from, input int to);
    for (int i = from; i < to; i++) begin
      chk({tag, ".play"}, 32'(play_out), 32'(exp_q[i]));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".idx"}, 32'(cur_idx), 32'(exp_idx_q[i]));
      chk({tag, ".done"}, 32'(done), 32'd0);
      tick();
    end
  endtask

  task automatic check_done(input string tag);
    chk({tag, ".done_hi"}, 32'(done), 32'd1);
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    chk({tag, ".done_play"}, 32'(play_out), 32'd0);
    tick();
    chk({tag, ".done_lo"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".play"}, 32'(play_out), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".idx"}, 32'(cur_idx), 32'd0);
  endtask

  task automatic write_324();
    write_mem(0, 3);
    write_mem(1, 2);
    write_mem(2, 4);
  endtask

  initial begin
    int n;
    int len;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Basic pass {3,2,4}: 9 cycles then done
    write_324();
    build_model(3);
    chk("model_len_324", 32'(exp_q.size()), 32'd9);
    start_play(3);
    check_pass("basic", 0, exp_q.size());
    check_done("basic");

    // Looped playback: two full wraps, then drop loop_en mid-pass
    loop_en = 1'b1;
    start_play(3);
    check_pass("loop1", 0, exp_q.size());
    check_pass("loop2", 0, exp_q.size());
    check_pass("loop3a", 0, 4);
    loop_en = 1'b0;
    check_pass("loop3b", 4, exp_q.size());
    check_done("loop");

    // Zero duration counts as one cycle
    write_mem(0, 0);
    write_mem(1, 5);
    build_model(2);
    chk("model_len_zero", 32'(exp_q.size()), 32'd6);
    start_play(2);
    check_pass("zero_dur", 0, exp_q.size());
    check_done("zero_dur");

    // seq_len = 0 is ignored
    start_play(0);
    for (int i = 0; i < 4; i++) begin
      check_idle("len0");
      tick();
    end

    // seq_len = 40 clamps to DEPTH entries
    for (int k = 0; k < DEPTH; k++) write_mem(k, $urandom_range(0, 4));
    build_model(40);
    start_play(40);
    check_pass("clamp", 0, exp_q.size());
    check_done("clamp");

    // Stop mid-playback
    write_324();
    build_model(3);
    start_play(3);
    check_pass("stop", 0, 4);
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    check_idle("stop_after");
    tick();
    check_idle("stop_nodone");

    // Reset mid-playback; memory survives
    start_play(3);
    check_pass("rst", 0, 4);
    rst_n = 1'b0;
    tick();
    check_idle("rst_after");
    rst_n = 1'b1;
    tick();
    check_idle("rst_noresume");
    start_play(3);
    check_pass("rst_replay", 0, exp_q.size());
    check_done("rst_replay");

    // Writes and start pulses while busy are ignored
    start_play(3);
    check_pass("busy_wr", 0, 2);
    wr_en = 1'b1; wr_idx = '0; wr_data = 99;
    start = 1'b1;
    check_pass("busy_wr", 2, 3);
    wr_en = 1'b0;
    start = 1'b0;
    check_pass("busy_wr", 3, exp_q.size());
    check_done("busy_wr");
    start_play(3);
    check_pass("after_busy_wr", 0, exp_q.size());
    check_done("after_busy_wr");

    // Randomized passes
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) write_mem(k, $urandom_range(0, 6));
      build_model(len);
      start_play(len);
      n = exp_q.size();
      check_pass("rand", 0, n);
      check_done("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
